avalon_main_pipeline_bridge: RTL and testbench



---
 rtl/avalon_bridge_pkg.sv | 38 +++
 rtl/avalon_skid_buffer.sv | 66 ++++++
 rtl/avalon_main_pipeline_bridge.sv | 128 ++++++++++++
 tb/tb_avalon_main_pipeline_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_bridge_pkg.sv
// -----------------------------------------------------------------------------
// avalon_bridge_pkg
// Shared types and constants for the Avalon-MM main pipeline bridge.
//   avm_cmd_t      : one buffered command (address, byteenable, write flag, data)
//   RESP_*         : Avalon response codes
//   sat_count()    : saturating up/down counter step used for read tracking
// -----------------------------------------------------------------------------
package avalon_bridge_pkg;

    localparam int AVM_ADDR_W = 32;
    localparam int AVM_DATA_W = 65;   // 64 data bits + tag bit
    localparam int AVM_BE_W   = 8;
    localparam int CNT_W      = 4;    // wide enough for up to 15 outstanding reads

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;
    localparam logic [1:0] RESP_DECODEERR = 2'b11;

    typedef struct packed {
        logic [AVM_ADDR_W-1:0] addr;
        logic [AVM_BE_W-1:0]   be;
        logic                  we;
        logic [AVM_DATA_W-1:0] wdata;
    } avm_cmd_t;

    // Simultaneous inc and dec cancel; the count never wraps in either direction.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                   input logic             inc,
                                                   input logic             dec,
                                                   input logic [CNT_W-1:0] max);
        sat_count = cnt;
        if (inc && !dec && cnt != max)
            sat_count = cnt + CNT_W'(1);
        else if (dec && !inc && cnt != '0)
            sat_count = cnt - CNT_W'(1);
    endfunction

endpackage

// File: rtl/avalon_skid_buffer.sv
// -----------------------------------------------------------------------------
// avalon_skid_buffer
// Two-entry skid buffer for avm_cmd_t with fully registered ready.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   in_valid_i/in_ready_o    : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i  : downstream handshake, out_data_o payload
// The output register feeds downstream; the skid register catches the one
// command that arrives in the cycle the output register is found stalled.
// -----------------------------------------------------------------------------
module avalon_skid_buffer
    import avalon_bridge_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  avm_cmd_t in_data_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output avm_cmd_t out_data_o
);

    logic     out_valid_q;
    logic     skid_valid_q;
    avm_cmd_t out_q;
    avm_cmd_t skid_q;
    logic     out_free;
    logic     push;

    // Output register may load when empty or when its content leaves this cycle.
    assign out_free    = !out_valid_q || out_ready_i;
    assign push        = in_valid_i && in_ready_o;
    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= push;
                if (push)
                    out_q <= in_data_i;
            end
        end else if (push) begin
            skid_valid_q <= 1'b1;
        end
    end

    // NOTE: skid payload has no reset; it is only observed when skid_valid_q
    // is set, so a reset on the data bits would buy nothing.
    always_ff @(posedge clk_i) begin
        if (push && !out_free)
            skid_q <= in_data_i;
    end

endmodule

// File: rtl/avalon_main_pipeline_bridge.sv
// -----------------------------------------------------------------------------
// avalon_main_pipeline_bridge
// Registered Avalon-MM bridge from the core data master to the interconnect.
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   s_*                        : upstream slave side (commands in, responses out)
//   m_*                        : downstream master side (commands out, responses in)
//   err_o                      : sticky protocol-error flag (cleared by reset only)
// Commands pass through a two-entry skid buffer; responses through one
// register stage. A credit counter bounds reads accepted but not yet returned.
// -----------------------------------------------------------------------------
module avalon_main_pipeline_bridge
    import avalon_bridge_pkg::*;
#(
    // Widths must match avm_cmd_t; only MAX_RD is meant to be overridden.
    parameter int ADDR_W = AVM_ADDR_W,
    parameter int DATA_W = AVM_DATA_W,
    parameter int BE_W   = AVM_BE_W,
    parameter int MAX_RD = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [BE_W-1:0]   s_byteenable,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    output logic              s_waitrequest,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_readdatavalid,
    output logic [1:0]        s_response,
    output logic [ADDR_W-1:0] m_address,
    output logic [BE_W-1:0]   m_byteenable,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic [1:0]        m_response,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] MAX_RD_C = CNT_W'(MAX_RD);

    avm_cmd_t          cmd_in;
    avm_cmd_t          cmd_out;
    logic              cmd_out_valid;
    logic              skid_ready;
    logic              accept;
    logic              rd_accept;
    logic              illegal;
    logic              m_rd_issue;
    logic              spurious;

    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;   // slave-side reads awaiting s_readdatavalid
    logic [CNT_W-1:0]  mo_cnt_q, mo_cnt_d;   // master-side reads awaiting m_readdatavalid
    logic              cred_full_q, cred_full_d;
    logic              err_q, err_d;
    logic              rdv_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;

    assign accept     = (s_read || s_write) && !s_waitrequest;
    // A read+write collision goes downstream as a write and takes no credit.
    assign rd_accept  = accept && s_read && !s_write;
    assign illegal    = accept && s_read && s_write;
    assign cmd_in     = '{addr: s_address, be: s_byteenable, we: s_write, wdata: s_writedata};

    avalon_skid_buffer u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (accept),
        .in_ready_o  (skid_ready),
        .in_data_i   (cmd_in),
        .out_valid_o (cmd_out_valid),
        .out_ready_i (!m_waitrequest),
        .out_data_o  (cmd_out)
    );

    assign m_read       = cmd_out_valid && !cmd_out.we;
    assign m_write      = cmd_out_valid && cmd_out.we;
    assign m_address    = cmd_out.addr;
    assign m_byteenable = cmd_out.be;
    assign m_writedata  = cmd_out.wdata;

    // Both terms are flops, so upstream sees no combinational path from m_*.
    assign s_waitrequest = !skid_ready || cred_full_q;

    assign m_rd_issue = m_read && !m_waitrequest;
    assign spurious   = m_readdatavalid && (mo_cnt_q == '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_cnt_d    = sat_count(rd_cnt_q, rd_accept, rdv_q, MAX_RD_C);
        // A spurious return does not cancel a read issued in the same cycle.
        mo_cnt_d    = sat_count(mo_cnt_q, m_rd_issue, m_readdatavalid && !spurious, '1);
        cred_full_d = (rd_cnt_d == MAX_RD_C);
        err_d       = err_q || illegal || spurious;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_cnt_q    <= '0;
            mo_cnt_q    <= '0;
            cred_full_q <= 1'b0;
            err_q       <= 1'b0;
            rdv_q       <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            mo_cnt_q    <= mo_cnt_d;
            cred_full_q <= cred_full_d;
            err_q       <= err_d;
            rdv_q       <= m_readdatavalid;
            if (m_readdatavalid) begin
                rdata_q <= m_readdata;
                resp_q  <= m_response;
            end
        end
    end

    assign s_readdatavalid = rdv_q;
    assign s_readdata      = rdata_q;
    assign s_response      = resp_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_avalon_main_pipeline_bridge.sv
// -----------------------------------------------------------------------------
// tb_avalon_main_pipeline_bridge
// Directed stimulus with a scoreboard: expected downstream commands and
// upstream responses are queued at issue time; a negedge monitor compares
// them against the DUT whenever m_read/m_write or s_readdatavalid is seen.
// -----------------------------------------------------------------------------
module tb_avalon_main_pipeline_bridge;
    import avalon_bridge_pkg::*;

    typedef struct packed {
        logic [64:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] s_address;
    logic [7:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [64:0] s_writedata;
    logic        s_waitrequest;
    logic [64:0] s_readdata;
    logic        s_readdatavalid;
    logic [1:0]  s_response;
    logic [31:0] m_address;
    logic [7:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic [64:0] m_writedata;
    logic        m_waitrequest;
    logic [64:0] m_readdata;
    logic        m_readdatavalid;
    logic [1:0]  m_response;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    avm_cmd_t cmd_q[$];
    rsp_t     rsp_q[$];
    avm_cmd_t mexp;
    rsp_t     rexp;

    avalon_main_pipeline_bridge #(.MAX_RD(4)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .s_address       (s_address),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_response      (s_response),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_response      (m_response),
        .err_o           (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        s_read  = 1'b0;
        s_write = 1'b0;
    endtask

    // Present a command, wait (bounded) for it to be accepted, queue its expected image.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [7:0] be, input logic [64:0] wdata, output int waits);
        avm_cmd_t c;
        s_read       = rd;
        s_write      = wr;
        s_address    = addr;
        s_byteenable = be;
        s_writedata  = wdata;
        waits = 0;
        while (s_waitrequest && waits < 200) begin
            cycle();
            waits++;
        end
        if (s_waitrequest) begin
            check("accept_timeout", s_waitrequest, 0);
        end else begin
            c.addr  = addr;
            c.be    = be;
            c.we    = wr;
            c.wdata = wdata;
            cmd_q.push_back(c);
        end
        cycle();
    endtask

    task automatic ret(input logic [64:0] data, input logic [1:0] resp);
        rsp_t r;
        m_readdatavalid = 1'b1;
        m_readdata      = data;
        m_response      = resp;
        r.data = data;
        r.resp = resp;
        rsp_q.push_back(r);
        cycle();
        m_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        cmd_q.delete();
        rsp_q.delete();
        cycle();
        rst_ni = 1'b1;
    endtask

    // Monitor: commands are compared every cycle they are presented (so a
    // stalled command must stay identical) and popped when accepted downstream.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (m_read || m_write) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", {m_read, m_write, m_address}, 0);
                end else begin
                    mexp = cmd_q[0];
                    check("cmd_addr", m_address, mexp.addr);
                    check("cmd_be", m_byteenable, mexp.be);
                    check("cmd_we", {m_read, m_write}, {!mexp.we, mexp.we});
                    check("cmd_wdata", m_writedata, mexp.wdata);
                    if (!m_waitrequest)
                        void'(cmd_q.pop_front());
                end
            end
            if (s_readdatavalid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", s_readdata, 0);
                end else begin
                    rexp = rsp_q.pop_front();
                    check("rsp_data", s_readdata, rexp.data);
                    check("rsp_resp", s_response, rexp.resp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst_ni          = 1'b0;
        s_address       = '0;
        s_byteenable    = '0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_writedata     = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;
        m_response      = 2'b00;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Reset state
        check("rst_waitreq", s_waitrequest, 0);
        check("rst_mcmd", {m_read, m_write, m_address, m_byteenable, m_writedata}, 0);
        check("rst_rsp", {s_readdatavalid, s_response, s_readdata}, 0);
        check("rst_err", err_o, 0);

        // Back-to-back writes, no stall: each appears on m_* the cycle after accept
        issue(0, 1, 32'h10, 8'hFF, 65'h0_1111_0000_0000_0010, w);
        check("b2b_wait0", w, 0);
        check("b2b_lat0", {m_write, m_address}, {1'b1, 32'h10});
        issue(0, 1, 32'h11, 8'h0F, 65'h1_2222_0000_0000_0011, w);
        check("b2b_wait1", w, 0);
        check("b2b_lat1", {m_write, m_address}, {1'b1, 32'h11});
        issue(0, 1, 32'h12, 8'hF0, 65'h0_3333_0000_0000_0012, w);
        check("b2b_wait2", w, 0);
        check("b2b_lat2", {m_write, m_address}, {1'b1, 32'h12});
        idle();
        cycle();

        // Downstream stall
        m_waitrequest = 1'b1;
        issue(0, 1, 32'h20, 8'h01, 65'h0_0000_0000_0000_0020, w);
        check("stall_wait0", w, 0);
        issue(0, 1, 32'h21, 8'h02, 65'h1_0000_0000_0000_0021, w);
        check("stall_wait1", w, 0);
        check("stall_wreq_rise", s_waitrequest, 1);
        s_address   = 32'h22;
        s_writedata = 65'h0_0000_0000_0000_0022;
        for (int i = 0; i < 3; i++) begin
            check("stall_wreq_hold", s_waitrequest, 1);
            check("stall_m_hold", m_address, 32'h20);
            cycle();
        end
        m_waitrequest = 1'b0;
        issue(0, 1, 32'h22, 8'h04, 65'h0_0000_0000_0000_0022, w);
        check("stall_release_wait", w, 1);
        idle();
        repeat (2) cycle();

        // Credit limit: four reads go, the fifth waits for a return
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 32'h30 + i, 8'hFF, '0, w);
            check("cred_wait", w, 0);
        end
        check("cred_full", s_waitrequest, 1);
        s_address = 32'h34;
        cycle();
        check("cred_full_hold", s_waitrequest, 1);
        ret(65'h1_DEAD_BEEF_0000_0001, RESP_OKAY);
        check("rdv_latency", s_readdatavalid, 1);
        check("rdv_data", s_readdata, 65'h1_DEAD_BEEF_0000_0001);
        issue(1, 0, 32'h34, 8'hFF, '0, w);
        check("cred_fifth_wait", w, 1);
        idle();

        // Bring rd_cnt to 3, then read accept coincides with s_readdatavalid
        ret(65'h0_0000_0000_0000_00A1, RESP_OKAY);
        repeat (2) cycle();
        check("cred_three", s_waitrequest, 0);
        m_readdatavalid = 1'b1;
        m_readdata      = 65'h1_0000_0000_0000_00B2;
        m_response      = RESP_SLVERR;
        rsp_q.push_back('{data: 65'h1_0000_0000_0000_00B2, resp: RESP_SLVERR});
        cycle();
        m_readdatavalid = 1'b0;
        issue(1, 0, 32'h35, 8'hFF, '0, w);
        check("simul_wait", w, 0);
        idle();
        check("simul_not_full", s_waitrequest, 0);
        cycle();
        check("simul_not_full2", s_waitrequest, 0);
        issue(1, 0, 32'h36, 8'hFF, '0, w);
        check("simul_wait2", w, 0);
        idle();
        check("simul_full_again", s_waitrequest, 1);

        // Drain the four outstanding reads, then a spurious return
        ret(65'h0_0000_0000_0000_00C3, RESP_OKAY);
        ret(65'h1_FFFF_FFFF_FFFF_FFFF, RESP_DECODEERR);
        ret(65'h0_0123_4567_89AB_CDEF, RESP_SLVERR);
        ret(65'h0_0000_0000_0000_00C6, RESP_OKAY);
        repeat (2) cycle();
        check("drain_wreq", s_waitrequest, 0);
        check("drain_err", err_o, 0);
        ret(65'h1_5A5A_5A5A_5A5A_5A5A, RESP_OKAY);
        cycle();
        check("spur_err", err_o, 1);
        repeat (3) cycle();
        check("spur_err_sticky", err_o, 1);

        // Illegal read+write goes as a write, takes no credit
        do_reset();
        check("reset_err_clear", err_o, 0);
        issue(1, 1, 32'h40, 8'h3C, 65'h1_0000_0000_0000_0040, w);
        check("illegal_wait", w, 0);
        idle();
        check("illegal_err", err_o, 1);
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 32'h41 + i, 8'hFF, '0, w);
            check("illegal_rd_wait", w, 0);
        end
        idle();
        check("illegal_no_credit", s_waitrequest, 0);
        cycle();

        // Reset mid-transfer with two buffered reads and rd_cnt=2
        do_reset();
        m_waitrequest = 1'b1;
        issue(1, 0, 32'h50, 8'hFF, '0, w);
        issue(1, 0, 32'h51, 8'hFF, '0, w);
        idle();
        check("midrst_buffered", s_waitrequest, 1);
        do_reset();
        m_waitrequest = 1'b0;
        check("midrst_waitreq", s_waitrequest, 0);
        check("midrst_mcmd", {m_read, m_write, m_address, m_byteenable, m_writedata}, 0);
        check("midrst_rsp", {s_readdatavalid, s_response, s_readdata, err_o}, 0);
        repeat (3) cycle();
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 32'h60 + i, 8'hFF, '0, w);
            check("midrst_cred_wait", w, 0);
        end
        idle();
        check("midrst_cred_full", s_waitrequest, 1);
        repeat (2) cycle();

        check("cmd_q_empty", cmd_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
